usb_rx_token_decoder: RTL and testbench
=======================================

Name: usb_rx_token_decoder

Overview:
Receive-side USB token-packet decoder. Consumes the unstuffed, NRZI-decoded serial bit stream and finds SYNC. It then captures and validates the PID, assembles the 11-bit address/endpoint field, and judges packet integrity via the external USB_crc_5 checker. It drives that checker's clear/shift_enable and reads back crc_check_5. Output is a one-cycle token strobe, or an error strobe, to the protocol FSM.

Parameters:
IDLE_TIMEOUT, 64, max clk cycles between consecutive shift_enable pulses inside a packet before abort (counter width = $clog2(IDLE_TIMEOUT+1))

Ports:
clk  input  1  system clock, all state on rising edge
n_rst  input  1  asynchronous active-low reset
d_orig  input  1  decoded data bit, valid when shift_enable=1, also wired directly to USB_crc_5.d_orig
shift_enable  input  1  one-cycle strobe per received (unstuffed) bit, LSB-first order
eop  input  1  one-cycle end-of-packet strobe from line receiver
crc_check_5  input  1  from USB_crc_5: 1 = CRC residual correct
crc_clear  output  1  registered one-cycle clear to USB_crc_5
crc_shift_enable  output  1  combinational: shift_enable AND state==DATA
token_valid  output  1  registered one-cycle strobe, good token received
token_err  output  1  registered one-cycle strobe, malformed token
token_pid  output  4  PID of last good token (held)
token_addr  output  7  address field (bits 0-6 of the 11-bit field) of last good token (held)
token_endp  output  4  endpoint field (bits 7-10) of last good token (held)
busy  output  1  1 whenever state != IDLE

Behaviour:
- Reset (async, n_rst=0): state=IDLE. All outputs 0: crc_clear, token_valid, token_err, token_pid, token_addr, token_endp, busy. Bit counters, shift registers and timeout counter cleared. Reset mid-packet discards the packet silently, with no err strobe.
- IDLE: 8-bit history of received bits. SYNC = arrival order 0,0,0,0,0,0,0,1. On SYNC: go to PID and pulse crc_clear on the next cycle.
- PID: collect 8 bits, LSB-first. Low nibble = PID, high nibble must equal ~PID.
  - After the 8th bit: if the check fails, go to IDLE and pulse token_err.
  - If PID is one of OUT=0001, IN=1001, SOF=0101, SETUP=1101: go to DATA.
  - Otherwise (non-token PID): go to IDLE silently.
- DATA: 16 bits (11 field + 5 CRC), each forwarded to the CRC via crc_shift_enable in the same cycle. The 11 field bits are shifted LSB-first into the addr/endp staging register. After the 16th bit: go to WAIT_EOP.
- WAIT_EOP: crc_check_5 is valid here (≥1 cycle after the last shift).
  - On eop with crc_check_5=1: copy staging to token_pid/addr/endp, then pulse token_valid.
  - On eop with crc_check_5=0: pulse token_err and leave held outputs unchanged.
  - Any shift_enable in WAIT_EOP (extra bit): token_err, go to IDLE.
  - Both cases above return to IDLE.
- eop in PID or DATA (short packet): token_err, go to IDLE.
- eop coincident with the 16th DATA bit: the bit is processed, then token_err (CRC not yet valid), go to IDLE.
- eop in IDLE: ignored.
- Timeout: the counter resets on every shift_enable, runs in PID/DATA/WAIT_EOP, and is cleared in IDLE. Reaching IDLE_TIMEOUT gives token_err and IDLE.
- Strobe latency: token_valid/token_err assert on the clk edge after the triggering eop/bit. They never assert together. Held fields update in the same edge as token_valid.
- SYNC detection is not re-armed until IDLE.

Decomposition:
- Shared package usb_rx_pkg:
  - state enum (IDLE, PID, DATA, WAIT_EOP)
  - PID constants (PID_OUT, PID_IN, PID_SOF, PID_SETUP)
  - SYNC_PATTERN 8'b1000_0000 (shift-register view, newest bit in MSB)
  - field widths: PID_W=4, ADDR_W=7, ENDP_W=4, CRC5_W=5
- No sub-module. USB_crc_5 is instantiated alongside this block at the parent level, not inside it.

Test Plan:
- Good OUT token: SYNC; PID bits 1,0,0,0,0,1,1,1; field+CRC bits 1,0,1,0,1,0,0,0,1,1,1,1,0,1,1,1; eop -> token_valid=1 one cycle, token_pid=4'h1, token_addr=7'h15, token_endp=4'hE, token_err=0; crc_shift_enable high for exactly 16 strobes.
- Same packet, last CRC bit flipped to 0 -> token_err=1 one cycle; held fields keep prior values (0 after reset).
- PID check fail (bits 1,0,0,0,1,1,1,1) -> token_err one cycle after 8th PID bit; state IDLE; no crc_shift_enable pulses.
- DATA PID 0011 with check nibble 1100 -> no strobes, returns IDLE, busy low.
- Short packet: eop after 10 DATA bits -> token_err. Extra 17th bit -> token_err. Gap of IDLE_TIMEOUT=64 cycles mid-DATA -> token_err.
- n_rst pulsed low during DATA bit 8 -> all outputs 0 immediately; a subsequent good token is decoded correctly.

Source files
------------

// File: rtl/usb_rx_pkg.sv
// Shared types and constants for the USB receive-side token path.
// Holds FSM states, token PID codes, SYNC pattern and field widths.
package usb_rx_pkg;

  typedef enum logic [1:0] {
    StIdle,
    StPid,
    StData,
    StWaitEop
  } state_e;

  localparam int unsigned PidW     = 4;
  localparam int unsigned AddrW    = 7;
  localparam int unsigned EndpW    = 4;
  localparam int unsigned Crc5W    = 5;
  localparam int unsigned FieldW   = AddrW + EndpW;
  localparam int unsigned DataBits = FieldW + Crc5W;

  localparam logic [PidW-1:0] PidOut   = 4'b0001;
  localparam logic [PidW-1:0] PidIn    = 4'b1001;
  localparam logic [PidW-1:0] PidSof   = 4'b0101;
  localparam logic [PidW-1:0] PidSetup = 4'b1101;

  // Shift-register view: newest bit enters at the MSB.
  localparam logic [7:0] SyncPattern = 8'b1000_0000;

  function automatic logic is_token_pid(input logic [PidW-1:0] pid);
    logic res;
    unique case (pid)
      PidOut, PidIn, PidSof, PidSetup: res = 1'b1;
      default:                         res = 1'b0;
    endcase
    return res;
  endfunction

endpackage

// File: rtl/usb_rx_token_decoder.sv
// USB token-packet decoder: finds SYNC, checks the PID, stages the 11-bit
// address/endpoint field and judges the packet with an external CRC5 checker.
module usb_rx_token_decoder
  import usb_rx_pkg::*;
#(
  parameter int unsigned IdleTimeout = 64
) (
  input  logic             clk,
  input  logic             n_rst,
  input  logic             d_orig,
  input  logic             shift_enable,
  input  logic             eop,
  input  logic             crc_check_5,
  output logic             crc_clear,
  output logic             crc_shift_enable,
  output logic             token_valid,
  output logic             token_err,
  output logic [PidW-1:0]  token_pid,
  output logic [AddrW-1:0] token_addr,
  output logic [EndpW-1:0] token_endp,
  output logic             busy
);

  localparam int unsigned TmoW     = $clog2(IdleTimeout + 1);
  localparam logic [3:0]  PidLast  = 4'd7;
  localparam logic [3:0]  FieldEnd = 4'(FieldW);
  localparam logic [3:0]  DataLast = 4'(DataBits - 1);

  state_e              state_q, state_d;
  logic [7:0]          sync_q, sync_d;
  logic [7:0]          pid_q, pid_d;
  logic [FieldW-1:0]   field_q, field_d;
  logic [3:0]          bit_cnt_q, bit_cnt_d;
  logic [TmoW-1:0]     tmo_q, tmo_d;
  logic                crc_clear_q, crc_clear_d;
  logic                valid_q, valid_d;
  logic                err_q, err_d;
  logic [PidW-1:0]     tok_pid_q, tok_pid_d;
  logic [AddrW-1:0]    tok_addr_q, tok_addr_d;
  logic [EndpW-1:0]    tok_endp_q, tok_endp_d;

  always_comb begin
    state_d     = state_q;
    sync_d      = sync_q;
    pid_d       = pid_q;
    field_d     = field_q;
    bit_cnt_d   = bit_cnt_q;
    tmo_d       = '0;
    crc_clear_d = 1'b0;
    valid_d     = 1'b0;
    err_d       = 1'b0;
    tok_pid_d   = tok_pid_q;
    tok_addr_d  = tok_addr_q;
    tok_endp_d  = tok_endp_q;

    if (state_q != StIdle) begin
      tmo_d = shift_enable ? '0 : tmo_q + TmoW'(1);
    end

    unique case (state_q)
      StIdle: begin
        if (shift_enable) begin
          sync_d = {d_orig, sync_q[7:1]};
          if (sync_d == SyncPattern) begin
            // History is wiped so SYNC cannot re-fire until the next IDLE.
            sync_d      = '0;
            bit_cnt_d   = '0;
            crc_clear_d = 1'b1;
            state_d     = StPid;
          end
        end
      end
      StPid: begin
        if (eop) begin
          err_d   = 1'b1;
          state_d = StIdle;
        end else if (shift_enable) begin
          pid_d     = {d_orig, pid_q[7:1]};
          bit_cnt_d = bit_cnt_q + 4'd1;
          if (bit_cnt_q == PidLast) begin
            bit_cnt_d = '0;
            if (pid_d[7:4] != ~pid_d[3:0]) begin
              err_d   = 1'b1;
              state_d = StIdle;
            end else if (is_token_pid(pid_d[3:0])) begin
              state_d = StData;
            end else begin
              state_d = StIdle;
            end
          end
        end
      end
      StData: begin
        if (shift_enable) begin
          if (bit_cnt_q < FieldEnd) begin
            field_d = {d_orig, field_q[FieldW-1:1]};
          end
          bit_cnt_d = bit_cnt_q + 4'd1;
          if (bit_cnt_q == DataLast) begin
            state_d = StWaitEop;
          end
        end
        // A coincident eop still lets the bit shift, but the CRC is not yet valid.
        if (eop) begin
          err_d   = 1'b1;
          state_d = StIdle;
        end
      end
      StWaitEop: begin
        if (shift_enable) begin
          err_d   = 1'b1;
          state_d = StIdle;
        end else if (eop) begin
          if (crc_check_5) begin
            valid_d    = 1'b1;
            tok_pid_d  = pid_q[3:0];
            tok_addr_d = field_q[AddrW-1:0];
            tok_endp_d = field_q[FieldW-1:AddrW];
          end else begin
            err_d = 1'b1;
          end
          state_d = StIdle;
        end
      end
      default: state_d = StIdle;
    endcase

    if (state_q != StIdle && state_d != StIdle && tmo_d == TmoW'(IdleTimeout)) begin
      err_d   = 1'b1;
      state_d = StIdle;
    end
    if (state_d == StIdle) begin
      tmo_d = '0;
    end
  end

  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      state_q     <= StIdle;
      sync_q      <= '0;
      pid_q       <= '0;
      field_q     <= '0;
      bit_cnt_q   <= '0;
      tmo_q       <= '0;
      crc_clear_q <= 1'b0;
      valid_q     <= 1'b0;
      err_q       <= 1'b0;
      tok_pid_q   <= '0;
      tok_addr_q  <= '0;
      tok_endp_q  <= '0;
    end else begin
      state_q     <= state_d;
      sync_q      <= sync_d;
      pid_q       <= pid_d;
      field_q     <= field_d;
      bit_cnt_q   <= bit_cnt_d;
      tmo_q       <= tmo_d;
      crc_clear_q <= crc_clear_d;
      valid_q     <= valid_d;
      err_q       <= err_d;
      tok_pid_q   <= tok_pid_d;
      tok_addr_q  <= tok_addr_d;
      tok_endp_q  <= tok_endp_d;
    end
  end

  assign crc_shift_enable = shift_enable && (state_q == StData);
  assign crc_clear        = crc_clear_q;
  assign token_valid      = valid_q;
  assign token_err        = err_q;
  assign token_pid        = tok_pid_q;
  assign token_addr       = tok_addr_q;
  assign token_endp       = tok_endp_q;
  assign busy             = (state_q != StIdle);

endmodule

// File: tb/tb_usb_rx_token_decoder.sv
// Randomized scoreboard bench for usb_rx_token_decoder, with a behavioural
// USB CRC5 checker standing in for the external USB_crc_5 block.
module tb_usb_rx_token_decoder;
  import usb_rx_pkg::*;

  localparam int unsigned Tmo = 64;

  logic       tb_clk = 1'b0;
  logic       n_rst = 1'b0;
  logic       d_orig = 1'b0;
  logic       shift_enable = 1'b0;
  logic       eop = 1'b0;
  logic       crc_check_5;
  logic       crc_clear, crc_shift_enable, token_valid, token_err, busy;
  logic [3:0] token_pid;
  logic [6:0] token_addr;
  logic [3:0] token_endp;

  always #5 tb_clk = ~tb_clk;

  usb_rx_token_decoder #(.IdleTimeout(Tmo)) dut (
    .clk              (tb_clk),
    .n_rst            (n_rst),
    .d_orig           (d_orig),
    .shift_enable     (shift_enable),
    .eop              (eop),
    .crc_check_5      (crc_check_5),
    .crc_clear        (crc_clear),
    .crc_shift_enable (crc_shift_enable),
    .token_valid      (token_valid),
    .token_err        (token_err),
    .token_pid        (token_pid),
    .token_addr       (token_addr),
    .token_endp       (token_endp),
    .busy             (busy)
  );

  function automatic logic [4:0] crc_step(input logic [4:0] c, input logic d);
    logic fb;
    fb = c[4] ^ d;
    return {c[3:0], 1'b0} ^ (fb ? 5'b00101 : 5'b00000);
  endfunction

  // External CRC5 checker: residual 01100 means the packet is intact.
  logic [4:0] crc_reg;
  always @(posedge tb_clk or negedge n_rst) begin
    if (!n_rst)                crc_reg <= 5'h1f;
    else if (crc_clear)        crc_reg <= 5'h1f;
    else if (crc_shift_enable) crc_reg <= crc_step(crc_reg, d_orig);
  end
  assign crc_check_5 = (crc_reg == 5'b01100);

  typedef struct {
    bit          is_err;
    int unsigned cyc;
    logic [3:0]  pid;
    logic [6:0]  addr;
    logic [3:0]  endp;
  } exp_t;

  exp_t        exp_q[$];
  exp_t        mon_e;
  int          n_cmp = 0;
  int          n_bad = 0;
  int unsigned cyc = 0;
  int unsigned n_crc = 0;
  int unsigned n_clr = 0;
  logic [3:0]  m_pid = '0;
  logic [6:0]  m_addr = '0;
  logic [3:0]  m_endp = '0;

  always @(posedge tb_clk) cyc <= cyc + 1;

  function automatic void check(input string name, input bit ok, input string detail);
    n_cmp++;
    if (!ok) begin
      n_bad++;
      $display("FAIL %s: %s", name, detail);
    end
  endfunction

  // Monitor: every strobe must match the oldest outstanding expectation.
  always @(negedge tb_clk) begin
    if (n_rst) begin
      if (crc_shift_enable) n_crc++;
      if (crc_clear) n_clr++;
      if (token_valid || token_err) begin
        if (exp_q.size() == 0) begin
          check("unexpected_strobe", 1'b0, $sformatf("got valid=%0b err=%0b at cyc %0d, none expected",
                token_valid, token_err, cyc));
        end else begin
          mon_e = exp_q.pop_front();
          check("strobe", token_valid == !mon_e.is_err && token_err == mon_e.is_err &&
                cyc == mon_e.cyc && token_pid == mon_e.pid && token_addr == mon_e.addr &&
                token_endp == mon_e.endp,
                $sformatf("got v=%0b e=%0b cyc=%0d pid=%h addr=%h endp=%h, need v=%0b e=%0b cyc=%0d pid=%h addr=%h endp=%h",
                token_valid, token_err, cyc, token_pid, token_addr, token_endp,
                !mon_e.is_err, mon_e.is_err, mon_e.cyc, mon_e.pid, mon_e.addr, mon_e.endp));
        end
      end
    end
  end

  task automatic idle(input int unsigned n);
    repeat (n) begin
      @(posedge tb_clk);
      #1;
    end
  endtask

  task automatic gap();
    idle($urandom_range(0, 3));
  endtask

  task automatic bit_tx(input logic d, input logic e, output int unsigned ed);
    d_orig = d;
    shift_enable = 1'b1;
    eop = e;
    @(posedge tb_clk);
    #1;
    shift_enable = 1'b0;
    eop = 1'b0;
    ed = cyc;
  endtask

  task automatic eop_tx(output int unsigned ed);
    eop = 1'b1;
    @(posedge tb_clk);
    #1;
    eop = 1'b0;
    ed = cyc;
  endtask

  task automatic send_bits(input logic [15:0] b, input int n, output int unsigned ed);
    for (int i = 0; i < n; i++) begin
      bit_tx(b[i], 1'b0, ed);
      if (i < n - 1) gap();
    end
  endtask

  task automatic expect_strobe(input bit is_err, input int unsigned cy);
    exp_t x;
    x.is_err = is_err;
    x.cyc = cy;
    x.pid = m_pid;
    x.addr = m_addr;
    x.endp = m_endp;
    exp_q.push_back(x);
  endtask

  task automatic send_sync();
    int unsigned ed;
    if ($urandom_range(0, 1) == 1) begin
      eop_tx(ed);
      gap();
    end
    for (int i = 0; i < 8; i++) begin
      bit_tx(i == 7, 1'b0, ed);
      if (i == 7) check("busy_after_sync", busy === 1'b1, $sformatf("busy=%b, need 1", busy));
      gap();
    end
  endtask

  function automatic logic [7:0] pbyte(input logic [3:0] p);
    return {~p, p};
  endfunction

  function automatic logic [3:0] rand_token();
    logic [3:0] t[4];
    t[0] = PidOut;
    t[1] = PidIn;
    t[2] = PidSof;
    t[3] = PidSetup;
    return t[$urandom_range(0, 3)];
  endfunction

  // Field bits LSB-first, then the inverted CRC5 MSB-first.
  function automatic logic [15:0] data_bits(input logic [10:0] f);
    logic [4:0]  c;
    logic [15:0] r;
    c = 5'h1f;
    for (int i = 0; i < 11; i++) c = crc_step(c, f[i]);
    r[10:0] = f;
    for (int i = 0; i < 5; i++) r[11+i] = ~c[4-i];
    return r;
  endfunction

  task automatic tok(input logic [3:0] p, input logic [10:0] fld, input int flip);
    logic [15:0] db;
    int unsigned ed;
    db = data_bits(fld);
    if (flip >= 0) db[flip] = ~db[flip];
    send_sync();
    send_bits({8'h00, pbyte(p)}, 8, ed);
    gap();
    send_bits(db, 16, ed);
    gap();
    eop_tx(ed);
    if (flip < 0) begin
      m_pid = p;
      m_addr = fld[6:0];
      m_endp = fld[10:7];
    end
    expect_strobe(flip >= 0, ed);
  endtask

  task automatic run_packet(input int kind);
    int unsigned crc0, clr0, exp_crc, ed, k;
    logic [3:0]  p, c;
    logic [15:0] db;
    crc0 = n_crc;
    clr0 = n_clr;
    exp_crc = 0;
    p = rand_token();
    db = data_bits(11'($urandom));
    case (kind)
      0: begin tok(p, 11'($urandom), -1); exp_crc = 16; end
      1: begin tok(p, 11'($urandom), int'($urandom_range(0, 15))); exp_crc = 16; end
      2: begin
        p = 4'($urandom);
        c = ~p ^ 4'($urandom_range(1, 15));
        send_sync();
        send_bits({8'h00, c, p}, 8, ed);
        expect_strobe(1'b1, ed);
      end
      3: begin
        do p = 4'($urandom); while (is_token_pid(p));
        send_sync();
        send_bits({8'h00, pbyte(p)}, 8, ed);
      end
      4: begin
        k = $urandom_range(0, 7);
        send_sync();
        if (k > 0) send_bits(16'($urandom), int'(k), ed);
        gap();
        eop_tx(ed);
        expect_strobe(1'b1, ed);
      end
      5: begin
        k = $urandom_range(0, 15);
        send_sync();
        send_bits({8'h00, pbyte(p)}, 8, ed);
        gap();
        if (k > 0) send_bits(db, int'(k), ed);
        gap();
        eop_tx(ed);
        expect_strobe(1'b1, ed);
        exp_crc = k;
      end
      6: begin
        send_sync();
        send_bits({8'h00, pbyte(p)}, 8, ed);
        gap();
        send_bits(db, 16, ed);
        gap();
        bit_tx(1'($urandom), 1'b0, ed);
        expect_strobe(1'b1, ed);
        gap();
        eop_tx(ed);
        exp_crc = 16;
      end
      7: begin
        k = $urandom_range(0, 16);
        send_sync();
        send_bits({8'h00, pbyte(p)}, 8, ed);
        if (k > 0) begin
          gap();
          send_bits(db, int'(k), ed);
        end
        expect_strobe(1'b1, ed + Tmo);
        idle(Tmo + 2);
        exp_crc = k;
      end
      default: begin
        send_sync();
        send_bits({8'h00, pbyte(p)}, 8, ed);
        gap();
        send_bits(db, 15, ed);
        gap();
        bit_tx(db[15], 1'b1, ed);
        expect_strobe(1'b1, ed);
        exp_crc = 16;
      end
    endcase
    idle(4);
    check($sformatf("crc_shifts_k%0d", kind), (n_crc - crc0) == exp_crc,
          $sformatf("got %0d, need %0d", n_crc - crc0, exp_crc));
    check($sformatf("crc_clears_k%0d", kind), (n_clr - clr0) == 1,
          $sformatf("got %0d, need 1", n_clr - clr0));
    check($sformatf("idle_after_k%0d", kind), busy === 1'b0 && exp_q.size() == 0,
          $sformatf("busy=%b pending=%0d, need 0/0", busy, exp_q.size()));
  endtask

  initial begin
    int unsigned ed;
    logic [15:0] db;
    repeat (3) @(posedge tb_clk);
    #1;
    check("reset_outputs", {crc_clear, crc_shift_enable, token_valid, token_err, token_pid,
          token_addr, token_endp, busy} === '0, "outputs not all 0 in reset");
    n_rst = 1'b1;
    idle(2);

    // Directed: bad last CRC bit first (held fields still 0), then the good OUT token.
    tok(PidOut, {4'hE, 7'h15}, 15);
    idle(4);
    check("bad_crc_held", token_pid == 4'h0 && token_addr == 7'h00 && token_endp == 4'h0,
          $sformatf("pid=%h addr=%h endp=%h, need 0/0/0", token_pid, token_addr, token_endp));
    run_packet(0);
    tok(PidOut, {4'hE, 7'h15}, -1);
    idle(4);
    check("good_out_fields", token_pid == 4'h1 && token_addr == 7'h15 && token_endp == 4'hE,
          $sformatf("pid=%h addr=%h endp=%h, need 1/15/e", token_pid, token_addr, token_endp));

    for (int n = 0; n < 60; n++) run_packet(int'($urandom_range(0, 8)));
    for (int kk = 0; kk < 9; kk++) run_packet(kk);

    // Reset while DATA bit 8 is on the wire.
    db = data_bits(11'($urandom));
    send_sync();
    send_bits({8'h00, pbyte(PidIn)}, 8, ed);
    send_bits(db, 7, ed);
    d_orig = db[7];
    shift_enable = 1'b1;
    #2;
    n_rst = 1'b0;
    #1;
    check("reset_mid_packet", {crc_clear, crc_shift_enable, token_valid, token_err, token_pid,
          token_addr, token_endp, busy} === '0, "outputs not all 0 after mid-packet reset");
    shift_enable = 1'b0;
    m_pid = '0;
    m_addr = '0;
    m_endp = '0;
    idle(3);
    n_rst = 1'b1;
    idle(2);
    run_packet(0);

    idle(10);
    check("queue_drained", exp_q.size() == 0, $sformatf("pending=%0d, need 0", exp_q.size()));
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
